// File: rtl/seg7_scan_if.sv
// Display bus between a value source and the seg7_scan driver: shadow-load
// inputs toward the driver, multiplexed active-low segment/select outputs back.
interface seg7_scan_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  blank_mask;
  logic [3:0]  dp_mask;
  logic [7:0]  segout;
  logic [3:0]  segselect;

  modport master (
    output value, load, blank_mask, dp_mask,
    input  segout, segselect
  );

  modport slave (
    input  value, load, blank_mask, dp_mask,
    output segout, segselect
  );
endinterface

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scan driver with shadow capture and
// inter-digit dead time. Define SEG7_SCAN_LZS_EN for leading-zero suppression.
module seg7_scan #(
  parameter int SCAN_W   = 13,
  parameter int DEAD_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  seg7_scan_if.slave bus
);

  localparam int CNT_W = (SCAN_W > 8) ? SCAN_W : 8;
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] LIT_LAST  = CNT_W'((64'd1 << SCAN_W) - 64'd1);

  typedef enum logic {DEAD = 1'b0, DRIVE = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      val_q;
  logic [3:0]       blank_q;
  logic [3:0]       dp_q;

  function automatic logic [7:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 8'h03;
      4'h1: decode = 8'h9F;
      4'h2: decode = 8'h25;
      4'h3: decode = 8'h0D;
      4'h4: decode = 8'h99;
      4'h5: decode = 8'h49;
      4'h6: decode = 8'h41;
      4'h7: decode = 8'h1F;
      4'h8: decode = 8'h01;
      4'h9: decode = 8'h09;
      4'hA: decode = 8'h11;
      4'hB: decode = 8'hC1;
      4'hC: decode = 8'h63;
      4'hD: decode = 8'h85;
      4'hE: decode = 8'h61;
      default: decode = 8'h71;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DEAD;
      cnt_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      blank_q <= '0;
      dp_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      // Shadow capture is independent of scan position so a load never restarts the scan.
      if (bus.load) begin
        val_q   <= bus.value;
        blank_q <= bus.blank_mask;
        dp_q    <= bus.dp_mask;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    case (state_q)
      DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == LIT_LAST) begin
          state_d = DEAD;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = DEAD;
        cnt_d   = '0;
      end
    endcase
  end

  logic [3:0] nib;
  logic [3:0] lz;
  logic       dark;

  assign nib = val_q[4*idx_q +: 4];

`ifdef SEG7_SCAN_LZS_EN
  // A digit is a leading zero when it and every digit to its left are zero; digit0 always shows.
  assign lz[3] = (val_q[15:12] == 4'h0);
  assign lz[2] = lz[3] && (val_q[11:8] == 4'h0);
  assign lz[1] = lz[2] && (val_q[7:4] == 4'h0);
  assign lz[0] = 1'b0;
`else
  assign lz = 4'b0000;
`endif

  assign dark = blank_q[idx_q] | lz[idx_q];

  always_comb begin
    bus.segselect = 4'b1111;
    bus.segout    = 8'hFF;
    if (state_q == DRIVE) begin
      bus.segselect = ~(4'b0001 << idx_q);
      if (!dark) begin
        bus.segout = decode(nib);
        if (dp_q[idx_q]) bus.segout[0] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan (SCAN_W=4, DEAD_CYC=2) with a cycle-level
// reference model feeding an expected-output queue.
module tb_seg7_scan;

  localparam int SW   = 4;
  localparam int DC   = 2;
  localparam int LIT  = 1 << SW;
  localparam int SLOT = DC + LIT;

  logic clk;
  logic rst;

  seg7_scan_if bus ();

  seg7_scan #(.SCAN_W(SW), .DEAD_CYC(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Reference model state
  int          m_t;
  logic [15:0] m_val;
  logic [3:0]  m_blank;
  logic [3:0]  m_dp;
  logic [11:0] exp_q[$];

  function automatic logic [7:0] ref_seg(input logic [3:0] n);
    logic [7:0] tbl [16];
    tbl = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
            8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    return tbl[n];
  endfunction

  function automatic logic [11:0] model_out();
    int ph, ix;
    logic [3:0] sel, nb;
    logic [7:0] sg;
    logic sup;
    ph = m_t % SLOT;
    if (ph < DC) return {4'hF, 8'hFF};
    ix  = (m_t / SLOT) % 4;
    sel = 4'hF;
    sel[ix] = 1'b0;
    nb  = m_val[4*ix +: 4];
    sg  = ref_seg(nb);
    if (m_dp[ix]) sg[0] = 1'b0;
    sup = 1'b0;
`ifdef SEG7_SCAN_LZS_EN
    if (ix > 0) begin
      sup = 1'b1;
      for (int k = ix; k < 4; k++)
        if (m_val[4*k +: 4] != 4'h0) sup = 1'b0;
    end
`endif
    if (m_blank[ix] || sup) sg = 8'hFF;
    return {sel, sg};
  endfunction

  task automatic check_now(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {bus.segselect, bus.segout};
    ntests++;
    assert (obs === exp)
      else begin
        nfail++;
        $error("FAIL %s t=%0d observed sel/seg=%h expected=%h", tag, m_t, obs, exp);
      end
  endtask

  task automatic model_reset();
    m_t = 0; m_val = '0; m_blank = '0; m_dp = '0;
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic tick(input logic ld, input logic [15:0] v,
                      input logic [3:0] bm, input logic [3:0] dm);
    bus.value = v; bus.load = ld; bus.blank_mask = bm; bus.dp_mask = dm;
    @(posedge clk);
    if (ld) begin m_val = v; m_blank = bm; m_dp = dm; end
    m_t++;
    exp_q.push_back(model_out());
    #1;
    check_now("scan", exp_q.pop_front());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, bus.value, bus.blank_mask, bus.dp_mask);
  endtask

  // Advance until the model is at the given slot position of a given digit.
  task automatic run_to(input int ix, input int ph);
    for (int i = 0; i < 4 * SLOT; i++) begin
      if (((m_t / SLOT) % 4 == ix) && (m_t % SLOT == ph)) break;
      tick(1'b0, bus.value, bus.blank_mask, bus.dp_mask);
    end
    ntests++;
    assert (((m_t / SLOT) % 4 == ix) && (m_t % SLOT == ph))
      else begin nfail++; $error("FAIL run_to position t=%0d target digit %0d phase %0d", m_t, ix, ph); end
  endtask

  initial begin
    rst = 1'b0;
    bus.value = '0; bus.load = 1'b0; bus.blank_mask = '0; bus.dp_mask = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_now("reset_hold", {4'hF, 8'hFF});
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_now("post_reset", model_out());

    // Scan order across two frames
    tick(1'b1, 16'h1234, 4'b0000, 4'b0000);
    run(2 * 4 * SLOT);

    // Hex digits with decimal point on digit1
    tick(1'b1, 16'hCE0F, 4'b0000, 4'b0010);
    run(4 * SLOT + 4);

    // Blanked digit3 keeps its select
    tick(1'b1, 16'h9999, 4'b1000, 4'b0000);
    run(4 * SLOT + 4);

    // Mid-digit load: digit0 showing 0, then switch to 8 without restarting the lit count
    tick(1'b1, 16'h0000, 4'b0000, 4'b0000);
    run_to(0, DC + 4);
    check_now("digit0_zero", {4'b1110, 8'h03});
    tick(1'b1, 16'h0008, 4'b0000, 4'b0000);
    check_now("midload_seg", {4'b1110, 8'h01});
    run(LIT - 6);
    check_now("lit_end", {4'b1110, 8'h01});
    tick(1'b0, bus.value, bus.blank_mask, bus.dp_mask);
    check_now("dead_after", {4'hF, 8'hFF});

    // Load held high re-captures every clock
    tick(1'b1, 16'h1111, 4'b0000, 4'b0000);
    tick(1'b1, 16'h2222, 4'b0000, 4'b0000);
    tick(1'b1, 16'h3333, 4'b0001, 4'b0100);
    run(4 * SLOT);

    // Leading-zero case
    tick(1'b1, 16'h0070, 4'b0000, 4'b0000);
    run(4 * SLOT + 2);

    // Asynchronous reset mid-DRIVE
    run_to(2, DC + 5);
    #2;
    rst = 1'b0;
    #1;
    check_now("async_reset_dark", {4'hF, 8'hFF});
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_now("restart", model_out());
    run(SLOT + 3);
    check_now("cleared_shadow_digit1", {4'b1101, 8'h03});
    run(4 * SLOT);

    ntests++;
    assert (exp_q.size() == 0)
      else begin nfail++; $error("FAIL queue_drain observed=%0d expected=0", exp_q.size()); end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
